// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding, default datapath width and the
// result-flag bit positions common to the adder and subtractor paths.
package alu_pkg;

   localparam int unsigned ALU_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int unsigned FLAG_BORROW   = 0;
   localparam int unsigned FLAG_OVERFLOW = 1;
   localparam int unsigned FLAG_ZERO     = 2;
   localparam int unsigned FLAG_W        = 3;

endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor: diff = a ^ b, borrow = ~a & b.
module half_subtractor
   import alu_pkg::*;
(
   input  logic a,
   input  logic b,
   output logic diff,
   output logic borrow
);

   assign diff   = a ^ b;
   assign borrow = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle a - b: DIGIT bits per clock, LSB first, through a ripple of
// full subtractors built from half subtractors; valid/ready on both sides.
module serial_subtractor
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH,
   parameter int unsigned DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             overflow,
   output logic             zero,
   output logic             busy
);

   localparam int unsigned N  = WIDTH / DIGIT;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   generate
      if (WIDTH % DIGIT != 0) begin : g_bad_digit
         $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
      end
   endgenerate

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q;
   logic [WIDTH-1:0]  a_sr, b_sr, dsr, diff_nxt, diff_q;
   logic              bin_q, a_msb_q, b_msb_q;
   logic [FLAG_W-1:0] flags_q;
   logic              accept, last;

   logic [DIGIT:0]    bc;
   logic [DIGIT-1:0]  dd;

   assign in_ready  = (state_q == ST_IDLE) & ~rst;
   assign accept    = in_valid & in_ready;
   assign last      = (cnt_q == CW'(N - 1));
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_RUN);

   assign diff     = diff_q;
   assign borrow   = flags_q[FLAG_BORROW];
   assign overflow = flags_q[FLAG_OVERFLOW];
   assign zero     = flags_q[FLAG_ZERO];

   // Borrow ripples across the digit; two half subtractors plus an OR per bit.
   assign bc[0] = bin_q;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fs
      logic d1, b1, b2;

      half_subtractor u_hs0 (
         .a      (a_sr[i]),
         .b      (b_sr[i]),
         .diff   (d1),
         .borrow (b1)
      );

      half_subtractor u_hs1 (
         .a      (d1),
         .b      (bc[i]),
         .diff   (dd[i]),
         .borrow (b2)
      );

      assign bc[i+1] = b1 | b2;
   end

   // New digit enters at the top; after N shifts the register holds the full result.
   assign diff_nxt = (dsr >> DIGIT) | (WIDTH'(dd) << (WIDTH - DIGIT));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept)    state_d = ST_RUN;
         ST_RUN:  if (last)      state_d = ST_DONE;
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr    <= '0;
         b_sr    <= '0;
         dsr     <= '0;
         cnt_q   <= '0;
         bin_q   <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         diff_q  <= '0;
         flags_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  a_sr    <= a;
                  b_sr    <= b;
                  a_msb_q <= a[WIDTH-1];
                  b_msb_q <= b[WIDTH-1];
                  dsr     <= '0;
                  cnt_q   <= '0;
                  bin_q   <= 1'b0;
               end
            end
            ST_RUN: begin
               a_sr  <= a_sr >> DIGIT;
               b_sr  <= b_sr >> DIGIT;
               dsr   <= diff_nxt;
               bin_q <= bc[DIGIT];
               cnt_q <= cnt_q + CW'(1);
               if (last) begin
                  diff_q                 <= diff_nxt;
                  flags_q[FLAG_BORROW]   <= bc[DIGIT];
                  flags_q[FLAG_ZERO]     <= (diff_nxt == '0);
                  flags_q[FLAG_OVERFLOW] <= (a_msb_q != b_msb_q) &&
                                            (diff_nxt[WIDTH-1] != a_msb_q);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench: default (DIGIT=1) and DIGIT=4 builds driven side by side
// from one vector table, plus backpressure and reset-abort sequences.
module tb_serial_subtractor;

   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready;
   logic [31:0] a, b;

   logic        in_ready1, out_valid1, borrow1, overflow1, zero1, busy1;
   logic [31:0] diff1;
   logic        in_ready4, out_valid4, borrow4, overflow4, zero4, busy4;
   logic [31:0] diff4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(32), .DIGIT(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
      .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
      .diff(diff1), .borrow(borrow1), .overflow(overflow1), .zero(zero1), .busy(busy1)
   );

   serial_subtractor #(.WIDTH(32), .DIGIT(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
      .a(a), .b(b), .out_valid(out_valid4), .out_ready(out_ready),
      .diff(diff4), .borrow(borrow4), .overflow(overflow4), .zero(zero4), .busy(busy4)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] d;
      logic        bo;
      logic        ov;
      logic        z;
   } vec_t;

   vec_t vt [10];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_results(input string tag, input logic [31:0] d,
                                input logic bo, input logic ov, input logic z);
      check({tag, " diff1"},  diff1, d);
      check({tag, " flags1"}, {29'd0, borrow1, overflow1, zero1}, {29'd0, bo, ov, z});
      check({tag, " diff4"},  diff4, d);
      check({tag, " flags4"}, {29'd0, borrow4, overflow4, zero4}, {29'd0, bo, ov, z});
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " out_valid"}, {30'd0, out_valid1, out_valid4}, 32'd0);
      check({tag, " busy"},      {30'd0, busy1, busy4}, 32'd0);
      check_results(tag, 32'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                         output int lat1, output int lat4);
      check("pre_accept in_ready", {30'd0, in_ready1, in_ready4}, 32'd3);
      a = av;
      b = bv;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      a = ~av;
      b = ~bv;
      lat1 = -1;
      lat4 = -1;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (k == 1) begin
            check("run busy1", {31'd0, busy1}, 32'd1);
            check("run in_ready1", {31'd0, in_ready1}, 32'd0);
         end
         if (out_valid1 && lat1 < 0) lat1 = k;
         if (out_valid4 && lat4 < 0) lat4 = k;
         if (lat1 >= 0 && lat4 >= 0) break;
      end
      check("latency1", 32'(lat1), 32'd32);
      check("latency4", 32'(lat4), 32'd8);
   endtask

   task automatic consume();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("consume out_valid", {30'd0, out_valid1, out_valid4}, 32'd0);
      check("consume in_ready",  {30'd0, in_ready1, in_ready4}, 32'd3);
   endtask

   initial begin
      int l1, l4;
      logic rose;

      vt[0] = '{32'h00000005, 32'h00000003, 32'h00000002, 1'b0, 1'b0, 1'b0};
      vt[1] = '{32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
      vt[2] = '{32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
      vt[3] = '{32'h1234ABCD, 32'h1234ABCD, 32'h00000000, 1'b0, 1'b0, 1'b1};
      vt[4] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1, 1'b0};
      vt[5] = '{32'h00000000, 32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b0};
      vt[6] = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
      vt[7] = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
      vt[8] = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1};
      vt[9] = '{32'hDEADBEEF, 32'h12345678, 32'hCC796877, 1'b0, 1'b0, 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      step();
      step();
      check("rst in_ready", {30'd0, in_ready1, in_ready4}, 32'd0);
      check_reset_outputs("reset");
      rst = 1'b0;
      #1;
      check("idle in_ready", {30'd0, in_ready1, in_ready4}, 32'd3);

      for (int i = 0; i < 10; i++) begin
         run_op(vt[i].a, vt[i].b, l1, l4);
         check_results($sformatf("vec%0d", i), vt[i].d, vt[i].bo, vt[i].ov, vt[i].z);
         consume();
      end

      // backpressure: results must hold for 10 cycles with out_ready low
      run_op(32'hA5A5A5A5, 32'h5A5A5A5A, l1, l4);
      for (int k = 0; k < 10; k++) begin
         step();
         check_results($sformatf("hold%0d", k), 32'h4B4B4B4B, 1'b0, 1'b1, 1'b0);
         check("hold valid/ready", {28'd0, out_valid1, out_valid4, in_ready1, in_ready4},
               32'b1100);
      end
      consume();

      // reset at accept+10 aborts the op; rst with in_valid accepts nothing
      a = 32'd5;
      b = 32'd3;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int k = 1; k <= 9; k++) step();
      rst = 1'b1;
      step();
      check("rst mid in_ready", {30'd0, in_ready1, in_ready4}, 32'd0);
      a = 32'd7;
      in_valid = 1'b1;
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      check_reset_outputs("abort");
      rose = 1'b0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (out_valid1 || out_valid4 || busy1 || busy4) rose = 1'b1;
      end
      check("abort no activity", {31'd0, rose}, 32'd0);
      check_reset_outputs("abort idle");

      run_op(32'd7, 32'd2, l1, l4);
      check_results("post_reset", 32'd5, 1'b0, 1'b0, 1'b0);
      consume();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
